vending_machine_inv: RTL and testbench

Parametrised next-generation vending controller. Supports N products with run-time programmable price and stock. Returns change one coin at a time over a valid/ack handshake, and auto-refunds after an inactivity timeout. Sits between the coin-acceptor/keypad front end and the dispenser/coin-hopper drivers.

---
 rtl/vending_machine_inv.sv | 209 ++++++++++++++++++++
 tb/tb_vending_machine_inv.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_inv.sv
// Vending controller: programmable price/stock, greedy change over valid/ack, inactivity refund.
// Optional sales counters are enabled by defining VENDING_SALES_STATS_EN.
module vending_machine_inv #(
  parameter int unsigned N_PRODUCTS     = 8,
  parameter int unsigned SEL_W          = (N_PRODUCTS > 1) ? $clog2(N_PRODUCTS) : 1,
  parameter int unsigned VAL_W          = 8,
  parameter int unsigned STOCK_W        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_we,
  input  logic [SEL_W-1:0]   cfg_addr,
  input  logic [VAL_W-1:0]   cfg_price,
  input  logic [STOCK_W-1:0] cfg_stock,
  input  logic [SEL_W-1:0]   product_select,
  input  logic               select_btn,
  input  logic [4:0]         coin_in,
  input  logic               coin_insert,
  input  logic               cancel,
  input  logic               coin_out_ack,
  output logic [VAL_W-1:0]   current_balance,
  output logic [VAL_W-1:0]   product_price,
  output logic               product_dispensed,
  output logic [SEL_W-1:0]   dispensed_id,
  output logic               coin_out_valid,
  output logic [4:0]         coin_out_value,
  output logic               coin_reject,
  output logic               sold_out,
`ifdef VENDING_SALES_STATS_EN
  output logic [31:0]        total_revenue,
  output logic [15:0]        total_sales,
`endif
  output logic [2:0]         state_out,
  output logic               transaction_complete
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StSelected = 3'd1;
  localparam logic [2:0] StAccept   = 3'd2;
  localparam logic [2:0] StDispense = 3'd3;
  localparam logic [2:0] StChange   = 3'd4;

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);

  logic [2:0]         state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [VAL_W-1:0]   lat_price_q, lat_price_d;
  logic [VAL_W-1:0]   balance_q, balance_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               sold_out_q, sold_out_d;
  logic               coin_reject_q, coin_reject_d;
  logic [VAL_W-1:0]   price_q [N_PRODUCTS];
  logic [STOCK_W-1:0] stock_q [N_PRODUCTS];

  logic               cfg_wr;
  logic               coin_ok;
  logic               coin_legal;
  logic               sel_avail;
  logic [VAL_W:0]     coin_sum;
  logic [4:0]         chg_coin;
  logic               chg_done;

  assign coin_legal = (coin_in == 5'd5) || (coin_in == 5'd10) || (coin_in == 5'd20);
  assign coin_sum   = {1'b0, balance_q} + (VAL_W + 1)'(coin_in);
  assign sel_avail  = (32'(product_select) < N_PRODUCTS) &&
                      (price_q[product_select] != '0) && (stock_q[product_select] != '0);

  // Greedy change: largest coin that still fits in the remaining balance.
  always_comb begin
    chg_coin = 5'd5;
    if (balance_q >= VAL_W'(20)) begin
      chg_coin = 5'd20;
    end else if (balance_q >= VAL_W'(10)) begin
      chg_coin = 5'd10;
    end
  end

  // Residue below the smallest coin cannot be paid out and is forfeited.
  assign chg_done = balance_q < VAL_W'(5);

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    lat_price_d   = lat_price_q;
    balance_d     = balance_q;
    tmr_d         = tmr_q;
    sold_out_d    = 1'b0;
    cfg_wr        = 1'b0;
    coin_ok       = 1'b0;

    case (state_q)
      StIdle: begin
        cfg_wr = cfg_we;
        if (select_btn) begin
          if (sel_avail) begin
            state_d     = StSelected;
            sel_d       = product_select;
            lat_price_d = price_q[product_select];
          end else begin
            sold_out_d = 1'b1;
          end
        end
      end
      StSelected: begin
        tmr_d = '0;
        if (cancel) begin
          state_d = StChange;
        end else begin
          state_d = StAccept;
          coin_ok = coin_insert && coin_legal && !coin_sum[VAL_W];
        end
      end
      StAccept: begin
        if (cancel || (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1))) begin
          state_d = StChange;
        end else begin
          coin_ok = coin_insert && coin_legal && !coin_sum[VAL_W];
          tmr_d   = coin_ok ? '0 : tmr_q + TMR_W'(1);
          if (balance_q >= lat_price_q) begin
            state_d = StDispense;
          end
        end
      end
      StDispense: begin
        balance_d = balance_q - lat_price_q;
        state_d   = StChange;
      end
      StChange: begin
        if (chg_done) begin
          balance_d = '0;
          state_d   = StIdle;
        end else if (coin_out_ack) begin
          balance_d = balance_q - VAL_W'(chg_coin);
        end
      end
      default: state_d = StIdle;
    endcase

    if (coin_ok) begin
      balance_d = coin_sum[VAL_W-1:0];
    end
    coin_reject_d = coin_insert && !coin_ok;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      sel_q         <= '0;
      lat_price_q   <= '0;
      balance_q     <= '0;
      tmr_q         <= '0;
      sold_out_q    <= 1'b0;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      lat_price_q   <= lat_price_d;
      balance_q     <= balance_d;
      tmr_q         <= tmr_d;
      sold_out_q    <= sold_out_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(N_PRODUCTS); i++) begin
        price_q[i] <= '0;
        stock_q[i] <= '0;
      end
    end else if (cfg_wr && (32'(cfg_addr) < N_PRODUCTS)) begin
      price_q[cfg_addr] <= cfg_price;
      stock_q[cfg_addr] <= cfg_stock;
    end else if (state_q == StDispense) begin
      stock_q[sel_q] <= stock_q[sel_q] - STOCK_W'(1);
    end
  end

`ifdef VENDING_SALES_STATS_EN
  logic [31:0] revenue_q;
  logic [15:0] sales_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      revenue_q <= '0;
      sales_q   <= '0;
    end else if (state_q == StDispense) begin
      revenue_q <= revenue_q + 32'(lat_price_q);
      sales_q   <= sales_q + 16'd1;
    end
  end

  assign total_revenue = revenue_q;
  assign total_sales   = sales_q;
`endif

  assign current_balance      = balance_q;
  assign product_price        = (state_q == StIdle) ? '0 : lat_price_q;
  assign product_dispensed    = (state_q == StDispense);
  assign dispensed_id         = product_dispensed ? sel_q : '0;
  assign coin_out_valid       = (state_q == StChange) && !chg_done;
  assign coin_out_value       = coin_out_valid ? chg_coin : 5'd0;
  assign coin_reject          = coin_reject_q;
  assign sold_out             = sold_out_q;
  assign state_out            = state_q;
  assign transaction_complete = (state_q == StChange) && chg_done;

endmodule

// File: tb/tb_vending_machine_inv.sv
// Directed self-checking bench for vending_machine_inv; expected values are hand-computed.
module tb_vending_machine_inv;

  logic       clk;
  logic       reset_n;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_price;
  logic [3:0] cfg_stock;
  logic [2:0] product_select;
  logic       select_btn;
  logic [4:0] coin_in;
  logic       coin_insert;
  logic       cancel;
  logic       coin_out_ack;
  logic [7:0] current_balance;
  logic [7:0] product_price;
  logic       product_dispensed;
  logic [2:0] dispensed_id;
  logic       coin_out_valid;
  logic [4:0] coin_out_value;
  logic       coin_reject;
  logic       sold_out;
  logic [2:0] state_out;
  logic       transaction_complete;
`ifdef VENDING_SALES_STATS_EN
  logic [31:0] total_revenue;
  logic [15:0] total_sales;
`endif

  int checks;
  int failures;

  vending_machine_inv dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .cfg_we              (cfg_we),
    .cfg_addr            (cfg_addr),
    .cfg_price           (cfg_price),
    .cfg_stock           (cfg_stock),
    .product_select      (product_select),
    .select_btn          (select_btn),
    .coin_in             (coin_in),
    .coin_insert         (coin_insert),
    .cancel              (cancel),
    .coin_out_ack        (coin_out_ack),
    .current_balance     (current_balance),
    .product_price       (product_price),
    .product_dispensed   (product_dispensed),
    .dispensed_id        (dispensed_id),
    .coin_out_valid      (coin_out_valid),
    .coin_out_value      (coin_out_value),
    .coin_reject         (coin_reject),
    .sold_out            (sold_out),
`ifdef VENDING_SALES_STATS_EN
    .total_revenue       (total_revenue),
    .total_sales         (total_sales),
`endif
    .state_out           (state_out),
    .transaction_complete(transaction_complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [2:0] a, input logic [7:0] p, input logic [3:0] s);
    cfg_we = 1'b1; cfg_addr = a; cfg_price = p; cfg_stock = s;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic sel(input logic [2:0] p);
    select_btn = 1'b1; product_select = p;
    tick();
    select_btn = 1'b0;
  endtask

  task automatic coin(input logic [4:0] v);
    coin_insert = 1'b1; coin_in = v;
    tick();
    coin_insert = 1'b0; coin_in = '0;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_price = '0; cfg_stock = '0;
    product_select = '0; select_btn = 1'b0; coin_in = '0; coin_insert = 1'b0;
    cancel = 1'b0; coin_out_ack = 1'b0;
    #3;
    chk("rst_state", 32'(state_out), 0);
    chk("rst_balance", 32'(current_balance), 0);
    chk("rst_price", 32'(product_price), 0);
    chk("rst_valid", 32'(coin_out_valid), 0);
    chk("rst_tc", 32'(transaction_complete), 0);
    tick();
    reset_n = 1'b1;
    tick();

    cfg(3'd0, 8'd15, 4'd2);
    cfg(3'd1, 8'd20, 4'd5);
    cfg(3'd2, 8'd10, 4'd1);
    cfg(3'd3, 8'd35, 4'd3);
    cfg(3'd4, 8'd40, 4'd3);

    // Coin while idle is refused.
    coin(5'd10);
    chk("idle_coin_reject", 32'(coin_reject), 1);
    chk("idle_coin_bal", 32'(current_balance), 0);

    // Product 0, exact payment 10+5.
    sel(3'd0);
    chk("t1_state_sel", 32'(state_out), 1);
    chk("t1_price", 32'(product_price), 15);
    coin(5'd10);
    chk("t1_bal10", 32'(current_balance), 10);
    chk("t1_state_acc", 32'(state_out), 2);
    coin(5'd5);
    chk("t1_bal15", 32'(current_balance), 15);
    tick();
    chk("t1_disp", 32'(product_dispensed), 1);
    chk("t1_disp_id", 32'(dispensed_id), 0);
    tick();
    chk("t1_state_chg", 32'(state_out), 4);
    chk("t1_no_change", 32'(coin_out_valid), 0);
    chk("t1_tc", 32'(transaction_complete), 1);
    tick();
    chk("t1_idle", 32'(state_out), 0);
    chk("t1_tc_low", 32'(transaction_complete), 0);

    // Product 1, overpay 20+20, change 20 held until ack.
    sel(3'd1);
    coin(5'd20);
    chk("t2_bal20", 32'(current_balance), 20);
    coin(5'd20);
    chk("t2_disp", 32'(product_dispensed), 1);
    chk("t2_disp_id", 32'(dispensed_id), 1);
    chk("t2_bal40", 32'(current_balance), 40);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold_valid", 32'(coin_out_valid), 1);
      chk("t2_hold_value", 32'(coin_out_value), 20);
      tick();
    end
    coin_out_ack = 1'b1;
    tick();
    coin_out_ack = 1'b0;
    chk("t2_after_ack_valid", 32'(coin_out_valid), 0);
    chk("t2_tc", 32'(transaction_complete), 1);
    tick();
    chk("t2_idle", 32'(state_out), 0);

    // Product 3, pay 20+10, cancel with a simultaneous coin.
    sel(3'd3);
    coin(5'd20);
    coin(5'd10);
    chk("t3_bal30", 32'(current_balance), 30);
    cancel = 1'b1; coin_insert = 1'b1; coin_in = 5'd5;
    tick();
    cancel = 1'b0; coin_insert = 1'b0; coin_in = '0;
    chk("t3_cancel_reject", 32'(coin_reject), 1);
    chk("t3_state_chg", 32'(state_out), 4);
    chk("t3_bal_kept", 32'(current_balance), 30);
    chk("t3_coin1", 32'(coin_out_value), 20);
    coin_out_ack = 1'b1;
    tick();
    chk("t3_no_disp", 32'(product_dispensed), 0);
    chk("t3_coin2", 32'(coin_out_value), 10);
    chk("t3_coin2_valid", 32'(coin_out_valid), 1);
    tick();
    coin_out_ack = 1'b0;
    chk("t3_tc", 32'(transaction_complete), 1);
    tick();

    // Product 2 has stock 1: buy once, second selection is sold out.
    sel(3'd2);
    coin(5'd10);
    tick();
    chk("t4_disp_id", 32'(dispensed_id), 2);
    tick();
    tick();
    sel(3'd2);
    chk("t4_sold_out", 32'(sold_out), 1);
    chk("t4_stay_idle", 32'(state_out), 0);
    tick();
    chk("t4_sold_out_pulse", 32'(sold_out), 0);

`ifdef VENDING_SALES_STATS_EN
    // Sales so far: 15 + 20 + 10.
    chk("stats_sales", 32'(total_sales), 3);
    chk("stats_revenue", total_revenue, 45);
`endif

    // Product 4: illegal coin, then 5, then inactivity refund.
    sel(3'd4);
    tick();
    chk("t5_state_acc", 32'(state_out), 2);
    coin(5'd15);
    chk("t5_bad_coin_reject", 32'(coin_reject), 1);
    chk("t5_bad_coin_bal", 32'(current_balance), 0);
    coin(5'd5);
    chk("t5_bal5", 32'(current_balance), 5);
    for (int i = 0; i < 63; i++) tick();
    chk("t5_before_timeout", 32'(state_out), 2);
    tick();
    chk("t5_timeout_chg", 32'(state_out), 4);
    chk("t5_refund_value", 32'(coin_out_value), 5);
    chk("t5_no_disp", 32'(product_dispensed), 0);

    // Asynchronous reset while change is pending.
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_state", 32'(state_out), 0);
    chk("t6_rst_valid", 32'(coin_out_valid), 0);
    chk("t6_rst_value", 32'(coin_out_value), 0);
    chk("t6_rst_bal", 32'(current_balance), 0);
    tick();
    reset_n = 1'b1;
    tick();
    // Prices were cleared by reset.
    sel(3'd0);
    chk("t6_cleared_sold_out", 32'(sold_out), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
